// File: rtl/array_ctrl_pkg.sv
// Shared constants and FSM state type for the 512x77 array controller.
package array_ctrl_pkg;
    localparam int              DEPTH      = 512;
    localparam int              AW         = 9;
    localparam int              DW         = 77;
    localparam logic [DW-1:0]   INIT_VALUE = '0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/array_0_3_ctrl_if.sv
// Request/response channels plus the SRAM macro port of the array controller.
interface array_0_3_ctrl_if;
    import array_ctrl_pkg::*;

    logic          init_req;
    logic          init_busy;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_resp_valid;
    logic          rd_resp_ready;
    logic [DW-1:0] rd_resp_data;
    logic          wr_req_valid;
    logic          wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          sram_r_en;
    logic [AW-1:0] sram_r_addr;
    logic [DW-1:0] sram_r_data;
    logic          sram_w_en;
    logic [AW-1:0] sram_w_addr;
    logic [DW-1:0] sram_w_data;
    logic          sram_w_mask;

    // Controller view.
    modport slave (
        input  init_req, rd_req_valid, rd_req_addr, rd_resp_ready,
        input  wr_req_valid, wr_req_addr, wr_req_data, sram_r_data,
        output init_busy, rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
        output sram_r_en, sram_r_addr, sram_w_en, sram_w_addr, sram_w_data, sram_w_mask
    );

    // Requester plus macro view.
    modport master (
        output init_req, rd_req_valid, rd_req_addr, rd_resp_ready,
        output wr_req_valid, wr_req_addr, wr_req_data, sram_r_data,
        input  init_busy, rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
        input  sram_r_en, sram_r_addr, sram_w_en, sram_w_addr, sram_w_data, sram_w_mask
    );
endinterface

// File: rtl/array_0_3_rsp_hold.sv
// Read response stage: presents macro read data the cycle after issue.
// Latency: 1 cycle from read accept to rsp_valid.
// Backpressure: a stalled response is captured into a hold register and replayed until accepted.
module array_0_3_rsp_hold
    import array_ctrl_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          rd_fire,
    input  logic [DW-1:0] sram_r_data,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data
);
    logic          pend_q;
    logic          hold_valid_q;
    logic [DW-1:0] hold_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            pend_q <= rd_fire;
            // Capture before a later write can change the macro output under the consumer.
            if (pend_q && !rsp_ready) begin
                hold_valid_q <= 1'b1;
                hold_q       <= sram_r_data;
            end else if (hold_valid_q && rsp_ready) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = pend_q | hold_valid_q;
    assign rsp_data  = hold_valid_q ? hold_q : sram_r_data;
endmodule

// File: rtl/array_0_3_ctrl.sv
// Controller for a 512x77 1R1W SRAM macro with init sweep and valid/ready channels.
// Latency: writes pass straight to the macro; read data valid 1 cycle after accept.
// Backpressure: one read outstanding; rd_req_ready drops while a response is stalled or init pending.
module array_0_3_ctrl
    import array_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    array_0_3_ctrl_if.slave   bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          init_pend_q, init_pend_d;
    logic          run_open;
    logic          in_init;
    logic          rsp_valid;
    logic          rd_fire;
    logic          wr_fire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_pend_q <= init_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_pend_d = init_pend_q;
        run_open    = 1'b0;
        case (state_q)
            INIT: begin
                if (init_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                run_open = !init_pend_q;
                // Sweep may start once the outstanding response leaves at this edge.
                if (init_pend_q && (!rsp_valid || bus.rd_resp_ready)) begin
                    state_d     = INIT;
                    init_cnt_d  = '0;
                    init_pend_d = 1'b0;
                end else if (bus.init_req) begin
                    init_pend_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign in_init          = (state_q == INIT);
    assign bus.wr_req_ready = run_open;
    assign bus.rd_req_ready = run_open && (!rsp_valid || bus.rd_resp_ready);
    assign bus.init_busy    = in_init || init_pend_q || bus.init_req;
    assign wr_fire          = bus.wr_req_valid && bus.wr_req_ready;
    assign rd_fire          = bus.rd_req_valid && bus.rd_req_ready;

    // Enables stay quiet while reset is held even though the FSM sits in INIT.
    assign bus.sram_w_en   = reset_n && (in_init || wr_fire);
    assign bus.sram_w_addr = in_init ? init_cnt_q : bus.wr_req_addr;
    assign bus.sram_w_data = in_init ? INIT_VALUE : bus.wr_req_data;
    assign bus.sram_w_mask = bus.sram_w_en;
    assign bus.sram_r_en   = rd_fire;
    assign bus.sram_r_addr = bus.rd_req_addr;

    array_0_3_rsp_hold u_rsp_hold (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_fire     (rd_fire),
        .sram_r_data (bus.sram_r_data),
        .rsp_ready   (bus.rd_resp_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (bus.rd_resp_data)
    );
    assign bus.rd_resp_valid = rsp_valid;
endmodule

// File: tb/tb_array_0_3_ctrl.sv
// Self-checking bench for array_0_3_ctrl with a behavioural SRAM macro and transaction-level reference.
module tb_array_0_3_ctrl;
    import array_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    array_0_3_ctrl_if bus ();
    array_0_3_ctrl dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    // Macro: write and read-address register on the same edge, data read from the registered address.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr_q;
    always @(posedge clock) begin
        if (bus.sram_w_en && bus.sram_w_mask) mem[bus.sram_w_addr] <= bus.sram_w_data;
        if (bus.sram_r_en) raddr_q <= bus.sram_r_addr;
    end
    assign bus.sram_r_data = mem[raddr_q];

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.init_req      = 1'b0;
        bus.rd_req_valid  = 1'b0;
        bus.rd_req_addr   = '0;
        bus.rd_resp_ready = 1'b1;
        bus.wr_req_valid  = 1'b0;
        bus.wr_req_addr   = '0;
        bus.wr_req_data   = '0;
    endtask

    task automatic test_reset();
        logic [5+AW+DW-1:0] got, exp;
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        got = {bus.init_busy, bus.rd_req_ready, bus.wr_req_ready, bus.rd_resp_valid, bus.sram_w_en, AW'(0), DW'(bus.sram_r_en)};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(0), DW'(0)};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.init_req     = (i == 100);
            bus.rd_req_valid = 1'b1;
            bus.wr_req_valid = 1'b1;
            @(negedge clock);
            got = {bus.init_busy, bus.sram_w_en, bus.sram_w_mask, bus.rd_req_ready, bus.wr_req_ready, bus.sram_w_addr, bus.sram_w_data};
            exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, AW'(i), INIT_VALUE};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL sweep_step%0d got=%h exp=%h", i, got, exp); end
            @(posedge clock); #1;
        end
        idle_inputs();
        @(negedge clock);
        got = {bus.init_busy, bus.rd_req_ready, bus.wr_req_ready, bus.rd_resp_valid, bus.sram_w_en, AW'(0), DW'(0)};
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, AW'(0), DW'(0)};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL sweep_done got=%h exp=%h", got, exp); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VALUE;
        tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        d = 77'h1_2345_6789_ABCD_EF01;
        bus.wr_req_valid = 1'b1; bus.wr_req_addr = 9'd5; bus.wr_req_data = d;
        @(negedge clock);
        checks++;
        if ({bus.wr_req_ready, bus.sram_w_en, bus.sram_w_addr, bus.sram_w_data} !== {1'b1, 1'b1, 9'd5, d}) begin
            failures++; $display("FAIL wr_passthru got=%b/%b/%h/%h exp=1/1/5/%h", bus.wr_req_ready, bus.sram_w_en, bus.sram_w_addr, bus.sram_w_data, d);
        end
        ref_mem[5] = d;
        tick();
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = 9'd5;
        @(negedge clock);
        checks++;
        if ({bus.rd_req_ready, bus.sram_r_en, bus.sram_r_addr, bus.rd_resp_valid} !== {1'b1, 1'b1, 9'd5, 1'b0}) begin
            failures++; $display("FAIL rd_issue got=%b/%b/%h/%b exp=1/1/5/0", bus.rd_req_ready, bus.sram_r_en, bus.sram_r_addr, bus.rd_resp_valid);
        end
        tick();
        bus.rd_req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.rd_resp_valid, bus.rd_resp_data} !== {1'b1, d}) begin
            failures++; $display("FAIL rd_resp5 got=%b/%h exp=1/%h", bus.rd_resp_valid, bus.rd_resp_data, d);
        end
        tick();
        @(negedge clock);
        checks++;
        if (bus.rd_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_resp_clear got=%b exp=0", bus.rd_resp_valid); end
        tick();
    endtask

    task automatic test_same_cycle();
        bus.wr_req_valid = 1'b1; bus.wr_req_addr = 9'd7; bus.wr_req_data = 77'hAA;
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = 9'd7;
        ref_mem[7] = 77'hAA;
        tick();
        idle_inputs();
        @(negedge clock);
        checks++;
        if ({bus.rd_resp_valid, bus.rd_resp_data} !== {1'b1, 77'hAA}) begin
            failures++; $display("FAIL same_cycle_rw got=%b/%h exp=1/aa", bus.rd_resp_valid, bus.rd_resp_data);
        end
        tick();
    endtask

    task automatic test_stall();
        bus.wr_req_valid = 1'b1; bus.wr_req_addr = 9'd9; bus.wr_req_data = 77'h55;
        tick();
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = 9'd9; bus.rd_resp_ready = 1'b0;
        tick();
        bus.rd_req_addr = 9'd3;
        bus.wr_req_valid = 1'b1; bus.wr_req_data = 77'h66;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if ({bus.rd_resp_valid, bus.rd_req_ready, bus.rd_resp_data} !== {1'b1, 1'b0, 77'h55}) begin
                failures++; $display("FAIL stall_cycle%0d got=%b/%b/%h exp=1/0/55", c, bus.rd_resp_valid, bus.rd_req_ready, bus.rd_resp_data);
            end
            tick();
        end
        ref_mem[9] = 77'h66;
        idle_inputs();
        @(negedge clock);
        checks++;
        if ({bus.rd_resp_valid, bus.rd_resp_data} !== {1'b1, 77'h55}) begin
            failures++; $display("FAIL stall_release got=%b/%h exp=1/55", bus.rd_resp_valid, bus.rd_resp_data);
        end
        tick();
        @(negedge clock);
        checks++;
        if (bus.rd_resp_valid !== 1'b0) begin failures++; $display("FAIL stall_drained got=%b exp=0", bus.rd_resp_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            bus.wr_req_valid = 1'b1; bus.wr_req_addr = AW'(k); bus.wr_req_data = rand_data();
            ref_mem[k] = bus.wr_req_data;
            tick();
        end
        idle_inputs();
        for (int k = 0; k <= 16; k++) begin
            bus.rd_req_valid = (k < 16);
            bus.rd_req_addr  = AW'(k % 16);
            @(negedge clock);
            if (k < 16) begin
                checks++;
                if (bus.rd_req_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%b exp=1", k, bus.rd_req_ready); end
            end
            if (k > 0) begin
                checks++;
                if ({bus.rd_resp_valid, bus.rd_resp_data} !== {1'b1, ref_mem[k-1]}) begin
                    failures++; $display("FAIL stream_resp%0d got=%b/%h exp=1/%h", k - 1, bus.rd_resp_valid, bus.rd_resp_data, ref_mem[k-1]);
                end
            end
            tick();
        end
        idle_inputs();
        @(negedge clock);
        checks++;
        if (bus.rd_resp_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b exp=0", bus.rd_resp_valid); end
        tick();
    endtask

    task automatic test_random();
        logic outstanding;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            bus.wr_req_valid  = 1'($urandom_range(0, 1));
            bus.wr_req_addr   = AW'($urandom_range(0, 15));
            bus.wr_req_data   = rand_data();
            bus.rd_req_valid  = 1'($urandom_range(0, 1));
            bus.rd_req_addr   = AW'($urandom_range(0, 15));
            bus.rd_resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            outstanding = (exp_q.size() > 0);
            checks++;
            if (bus.rd_resp_valid !== outstanding) begin failures++; $display("FAIL rand_valid c%0d got=%b exp=%b", c, bus.rd_resp_valid, outstanding); end
            if (outstanding) begin
                checks++;
                if (bus.rd_resp_data !== exp_q[0]) begin failures++; $display("FAIL rand_data c%0d got=%h exp=%h", c, bus.rd_resp_data, exp_q[0]); end
            end
            checks++;
            if ({bus.wr_req_ready, bus.rd_req_ready} !== {1'b1, (!outstanding || bus.rd_resp_ready)}) begin
                failures++; $display("FAIL rand_ready c%0d got=%b%b exp=1%b", c, bus.wr_req_ready, bus.rd_req_ready, (!outstanding || bus.rd_resp_ready));
            end
            if (outstanding && bus.rd_resp_ready) void'(exp_q.pop_front());
            if (bus.wr_req_valid) ref_mem[bus.wr_req_addr] = bus.wr_req_data;
            if (bus.rd_req_valid && (!outstanding || bus.rd_resp_ready)) exp_q.push_back(ref_mem[bus.rd_req_addr]);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                checks++;
                if ({bus.rd_resp_valid, bus.rd_resp_data} !== {1'b1, exp_q[0]}) begin
                    failures++; $display("FAIL rand_drain got=%b/%h exp=1/%h", bus.rd_resp_valid, bus.rd_resp_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
        @(negedge clock);
        checks++;
        if (bus.rd_resp_valid !== 1'b0) begin failures++; $display("FAIL rand_empty got=%b exp=0", bus.rd_resp_valid); end
        tick();
    endtask

    task automatic test_reinit();
        logic [DW-1:0] held;
        int n;
        bit done;
        bus.wr_req_valid = 1'b1; bus.wr_req_addr = 9'd5; bus.wr_req_data = rand_data() | {1'b1, 76'h0};
        ref_mem[5] = bus.wr_req_data;
        tick();
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = 9'd20; bus.rd_resp_ready = 1'b0;
        held = ref_mem[20];
        tick();
        bus.rd_req_valid = 1'b0;
        bus.init_req = 1'b1;
        bus.wr_req_valid = 1'b1; bus.wr_req_addr = 9'd30; bus.wr_req_data = 77'h3C;
        @(negedge clock);
        checks++;
        if ({bus.init_busy, bus.wr_req_ready, bus.sram_w_en, bus.sram_w_addr, bus.rd_resp_valid} !== {1'b1, 1'b1, 1'b1, 9'd30, 1'b1}) begin
            failures++; $display("FAIL init_req_cycle got=%b/%b/%b/%h/%b exp=1/1/1/1e/1", bus.init_busy, bus.wr_req_ready, bus.sram_w_en, bus.sram_w_addr, bus.rd_resp_valid);
        end
        tick();
        bus.init_req = 1'b0;
        bus.rd_req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({bus.init_busy, bus.rd_req_ready, bus.wr_req_ready, bus.sram_w_en, bus.sram_r_en, bus.rd_resp_valid, bus.rd_resp_data} !== {6'b100001, held}) begin
                failures++; $display("FAIL init_pend%0d got=%b%b%b%b%b%b/%h exp=100001/%h", c, bus.init_busy, bus.rd_req_ready, bus.wr_req_ready,
                                     bus.sram_w_en, bus.sram_r_en, bus.rd_resp_valid, bus.rd_resp_data, held);
            end
            tick();
        end
        idle_inputs();
        @(negedge clock);
        checks++;
        if ({bus.rd_resp_valid, bus.rd_resp_data, bus.sram_w_en} !== {1'b1, held, 1'b0}) begin
            failures++; $display("FAIL init_drain got=%b/%h/%b exp=1/%h/0", bus.rd_resp_valid, bus.rd_resp_data, bus.sram_w_en, held);
        end
        tick();
        @(negedge clock);
        checks++;
        if ({bus.init_busy, bus.sram_w_en, bus.sram_w_addr, bus.rd_resp_valid} !== {1'b1, 1'b1, 9'd0, 1'b0}) begin
            failures++; $display("FAIL reinit_start got=%b/%b/%h/%b exp=1/1/0/0", bus.init_busy, bus.sram_w_en, bus.sram_w_addr, bus.rd_resp_valid);
        end
        repeat (200) tick();
        @(negedge clock);
        checks++;
        if ({bus.sram_w_en, bus.sram_w_addr} !== {1'b1, 9'd200}) begin
            failures++; $display("FAIL sweep_at200 got=%b/%h exp=1/c8", bus.sram_w_en, bus.sram_w_addr);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.init_busy, bus.sram_w_en, bus.rd_req_ready, bus.rd_resp_valid} !== 4'b1000) begin
            failures++; $display("FAIL mid_reset got=%b%b%b%b exp=1000", bus.init_busy, bus.sram_w_en, bus.rd_req_ready, bus.rd_resp_valid);
        end
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clock);
            if (c == 0) begin
                checks++;
                if ({bus.sram_w_en, bus.sram_w_addr} !== {1'b1, 9'd0}) begin
                    failures++; $display("FAIL restart_addr got=%b/%h exp=1/0", bus.sram_w_en, bus.sram_w_addr);
                end
            end
            if (!bus.init_busy) done = 1'b1;
            else n++;
            tick();
        end
        checks++;
        if (!done || n != DEPTH) begin failures++; $display("FAIL restart_len got=%0d done=%0d exp=%0d", n, done, DEPTH); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VALUE;
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = 9'd5;
        tick();
        bus.rd_req_addr = 9'd30;
        @(negedge clock);
        checks++;
        if ({bus.rd_resp_valid, bus.rd_resp_data} !== {1'b1, ref_mem[5]}) begin
            failures++; $display("FAIL reinit_rd5 got=%b/%h exp=1/%h", bus.rd_resp_valid, bus.rd_resp_data, ref_mem[5]);
        end
        tick();
        bus.rd_req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.rd_resp_valid, bus.rd_resp_data} !== {1'b1, ref_mem[30]}) begin
            failures++; $display("FAIL reinit_rd30 got=%b/%h exp=1/%h", bus.rd_resp_valid, bus.rd_resp_data, ref_mem[30]);
        end
        tick();
    endtask

    initial begin
        raddr_q = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_data();
        test_reset();
        test_write_read();
        test_same_cycle();
        test_stall();
        test_back_to_back();
        test_random();
        test_reinit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
